// File: rtl/sprite_line_buffer_pkg.sv
// Shared types and constants for the sprite line buffer: entry layout,
// line width and erase-sequencer state encoding.
package sprite_line_buffer_pkg;

  localparam int unsigned LB_WIDTH    = 640;
  localparam int unsigned IDX_W       = 10;
  localparam int unsigned COLOR_W     = 8;
  localparam int unsigned Z_W         = 2;
  localparam int unsigned RSVD_W      = 2;
  localparam int unsigned COLL_MASK_W = 4;

  // Entry layout, MSB first: coll_mask[15:12], rsvd[11:10], z[9:8], color[7:0]
  typedef struct packed {
    logic [COLL_MASK_W-1:0] coll_mask;
    logic [RSVD_W-1:0]      rsvd;
    logic [Z_W-1:0]         z;
    logic [COLOR_W-1:0]     color;
  } lb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    INIT  = 2'd2
  } erase_state_e;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(LB_WIDTH);
  endfunction

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Render-write, composer-read, erase and collision signals of the line buffer.
interface sprite_line_buffer_if;
  import sprite_line_buffer_pkg::*;

  logic                   line_render_start;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [IDX_W-1:0]       wr_idx;
  lb_entry_t              wr_data;
  logic [IDX_W-1:0]       rd_idx;
  lb_entry_t              rd_data;
  logic                   erase_start;
  logic                   erase_busy;
  logic [COLL_MASK_W-1:0] collisions;
  logic                   collision_valid;

  modport master (
    output line_render_start, wr_valid, wr_idx, wr_data, rd_idx, erase_start,
    input  wr_ready, rd_data, erase_busy, collisions, collision_valid
  );

  modport slave (
    input  line_render_start, wr_valid, wr_idx, wr_data, rd_idx, erase_start,
    output wr_ready, rd_data, erase_busy, collisions, collision_valid
  );

endinterface

// File: rtl/sprite_line_buffer_bank_ram.sv
// One 640x16 line bank: registered read port, single write port,
// read-before-write on a same-address collision.
module lb_bank_ram
  import sprite_line_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_addr_i,
  output lb_entry_t        rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  lb_entry_t        wr_data_i
);

  lb_entry_t mem_q [LB_WIDTH];
  lb_entry_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i && idx_in_range(wr_addr_i)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Addresses past the line end read as transparent
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (idx_in_range(rd_addr_i)) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sprite_line_buffer.sv
// Double-banked sprite line buffer: first-opaque-wins render pipeline,
// composer read port, collision accumulation and a bank erase sequencer.
module sprite_line_buffer
  import sprite_line_buffer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sprite_line_buffer_if.slave lb
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LB_WIDTH - 1);

  erase_state_e           state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   erase_bank_q, erase_bank_d;

  logic                   bank_sel_q;
  logic                   rd_bank_q;

  logic                   s1_valid_q;
  logic [IDX_W-1:0]       s1_idx_q;
  lb_entry_t              s1_data_q;
  logic                   s1_bank_q;

  logic                   fwd_valid_q;
  logic [IDX_W-1:0]       fwd_idx_q;
  logic                   fwd_bank_q;
  logic [COLOR_W-1:0]     fwd_color_q;
  logic [COLL_MASK_W-1:0] fwd_mask_q;

  logic [COLL_MASK_W-1:0] acc_q;
  logic [COLL_MASK_W-1:0] collisions_q;
  logic                   coll_valid_q;

  logic                   wr_ready_c;
  logic                   wr_accept_c;
  logic                   erase_we_c;
  logic                   fwd_hit_c;
  logic [COLOR_W-1:0]     exist_color_c;
  logic [COLL_MASK_W-1:0] exist_mask_c;
  logic                   commit_c;
  logic                   commit_done_c;
  logic [COLL_MASK_W-1:0] coll_c;

  logic [IDX_W-1:0]       ram_rd_addr [2];
  lb_entry_t              ram_rd_data [2];
  logic                   ram_we      [2];
  logic [IDX_W-1:0]       ram_wr_addr [2];
  lb_entry_t              ram_wr_data [2];

  // ---------------------------------------------------------------------
  // Erase / init sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      erase_bank_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      erase_bank_q <= erase_bank_d;
    end
  end

  // INIT sweeps bank 0 then bank 1; ERASE sweeps the latched bank once
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    erase_bank_d = erase_bank_q;
    case (state_q)
      IDLE: begin
        if (lb.erase_start) begin
          state_d      = ERASE;
          ptr_d        = '0;
          erase_bank_d = ~bank_sel_q;
        end
      end
      ERASE: begin
        if (ptr_q == LAST_IDX) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      INIT: begin
        if (ptr_q == LAST_IDX) begin
          ptr_d = '0;
          if (erase_bank_q) begin
            state_d      = IDLE;
            erase_bank_d = 1'b0;
          end else begin
            erase_bank_d = 1'b1;
          end
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  assign erase_we_c = (state_q != IDLE);

  // Render writes stall only while the sequencer is clearing the render bank
  assign wr_ready_c  = !((state_q == INIT) ||
                         (state_q == ERASE && erase_bank_q == bank_sel_q));
  assign wr_accept_c = lb.wr_valid && wr_ready_c;

  // ---------------------------------------------------------------------
  // Render pipeline: stage 0 reads, stage 1 resolves and writes back
  // ---------------------------------------------------------------------
  assign fwd_hit_c = fwd_valid_q && (fwd_idx_q == s1_idx_q) &&
                     (fwd_bank_q == s1_bank_q);

  always_comb begin
    exist_color_c = ram_rd_data[s1_bank_q].color;
    exist_mask_c  = ram_rd_data[s1_bank_q].coll_mask;
    if (fwd_hit_c) begin
      exist_color_c = fwd_color_q;
      exist_mask_c  = fwd_mask_q;
    end
  end

  always_comb begin
    commit_c = 1'b0;
    coll_c   = '0;
    if (s1_valid_q && (s1_data_q.color != '0)) begin
      if (exist_color_c == '0) begin
        commit_c = 1'b1;
      end else begin
        coll_c = exist_mask_c & s1_data_q.coll_mask;
      end
    end
  end

  // The sequencer owns a bank's write port; a draining commit into it is dropped
  assign commit_done_c = commit_c && !(erase_we_c && erase_bank_q == s1_bank_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_data_q   <= '0;
      s1_bank_q   <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_bank_q  <= 1'b0;
      fwd_color_q <= '0;
      fwd_mask_q  <= '0;
    end else begin
      s1_valid_q  <= wr_accept_c && idx_in_range(lb.wr_idx);
      s1_idx_q    <= lb.wr_idx;
      s1_data_q   <= lb.wr_data;
      s1_bank_q   <= bank_sel_q;
      fwd_valid_q <= commit_done_c;
      fwd_idx_q   <= s1_idx_q;
      fwd_bank_q  <= s1_bank_q;
      fwd_color_q <= s1_data_q.color;
      fwd_mask_q  <= s1_data_q.coll_mask;
    end
  end

  // ---------------------------------------------------------------------
  // Bank select, collision reporting
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_q   <= 1'b0;
      rd_bank_q    <= 1'b0;
      acc_q        <= '0;
      collisions_q <= '0;
      coll_valid_q <= 1'b0;
    end else begin
      rd_bank_q    <= ~bank_sel_q;
      coll_valid_q <= lb.line_render_start;
      if (lb.line_render_start) begin
        bank_sel_q   <= ~bank_sel_q;
        collisions_q <= acc_q | coll_c;
        acc_q        <= '0;
      end else begin
        acc_q <= acc_q | coll_c;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bank port steering: render bank serves stage 0, display bank the composer
  // ---------------------------------------------------------------------
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_rd_addr[b] = (1'(b) == bank_sel_q) ? lb.wr_idx : lb.rd_idx;
      ram_we[b]      = 1'b0;
      ram_wr_addr[b] = s1_idx_q;
      ram_wr_data[b] = s1_data_q;
      if (erase_we_c && erase_bank_q == 1'(b)) begin
        ram_we[b]      = 1'b1;
        ram_wr_addr[b] = ptr_q;
        ram_wr_data[b] = '0;
      end else if (commit_c && s1_bank_q == 1'(b)) begin
        ram_we[b] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lb_bank_ram u_ram (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_i (ram_rd_addr[b]),
      .rd_data_o (ram_rd_data[b]),
      .wr_en_i   (ram_we[b]),
      .wr_addr_i (ram_wr_addr[b]),
      .wr_data_i (ram_wr_data[b])
    );
  end

  assign lb.wr_ready        = wr_ready_c;
  assign lb.rd_data         = ram_rd_data[rd_bank_q];
  assign lb.erase_busy      = erase_we_c;
  assign lb.collisions      = collisions_q;
  assign lb.collision_valid = coll_valid_q;

endmodule

// File: doc/sprite_line_buffer.md
SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: line_render_start  in  1  one-cycle pulse that swaps banks at the start of each rendered line.
REQ-003 SHALL have ports: wr_valid  in  1; wr_ready  out  1; wr_idx  in  10  pixel 0..639; wr_data  in  16  {coll_mask[15:12], rsvd[11:10], z[9:8], color[7:0]}.
REQ-004 SHALL have ports: rd_idx  in  10  composer pixel index; rd_data  out  16  display-bank entry.
REQ-005 SHALL have ports: erase_start  in  1  pulse that begins clearing the display bank.
REQ-006 SHALL have ports: erase_busy  out  1; collisions  out  4; collision_valid  out  1  one-cycle pulse.

Function
REQ-007 SHALL hold two banks of 640x16 RAM; bank_sel selects the render bank, and !bank_sel selects the display bank.
REQ-008 SHALL toggle bank_sel on the cycle after line_render_start.
REQ-009 SHALL return rd_data = display_bank[rd_idx] with 1-cycle latency, registered.
REQ-010 SHALL return rd_data = 0 for rd_idx >= 640.
REQ-011 SHALL accept a render write when wr_valid && wr_ready.
REQ-012 Stage 0 SHALL read render_bank[wr_idx].
REQ-013 Stage 1 SHALL compare the new write against the existing entry and write back.
REQ-014 SHALL commit only when new color != 0 and existing color == 0 (first opaque write wins).
REQ-015 SHALL write nothing when new color == 0.
REQ-016 When both existing and new colors are nonzero, SHALL OR (existing coll_mask & new coll_mask) into the collision accumulator and leave the entry unchanged.
REQ-017 On a stage-1 write to the same index as a stage-0 read, SHALL forward stage-1 data so that back-to-back writes to one pixel resolve correctly.
REQ-018 SHALL ignore and never commit writes with wr_idx >= 640.
REQ-019 A write accepted on cycle N SHALL be visible in RAM from cycle N+2.
REQ-020 On line_render_start, SHALL present collisions = accumulator | any pending stage-1 collision and pulse collision_valid.
REQ-021 The accumulator SHALL clear on the same cycle, and the pipeline SHALL drain into the old bank before the swap.
REQ-022 Erase FSM states SHALL be IDLE, ERASE, and INIT.
REQ-023 IDLE -> ERASE SHALL occur on erase_start; the FSM SHALL latch erase_bank = !bank_sel and set pointer = 0.
REQ-024 ERASE SHALL write 16'h0000 to erase_bank[pointer] each cycle, increment the pointer, and return to IDLE after writing address 639 (640 cycles).
REQ-025 erase_start while in ERASE or INIT SHALL be ignored.
REQ-026 erase_busy SHALL be 1 in ERASE and INIT.
REQ-027 If the banks swap during ERASE, erasing SHALL continue on erase_bank, which is now the render bank.
REQ-028 wr_ready SHALL be 0 while the FSM is in ERASE and erase_bank == bank_sel, or while in INIT; otherwise 1.
REQ-029 A display-bank read of an address being erased in the same cycle SHALL return the pre-erase data (read-before-write).

Reset
REQ-030 After rst: bank_sel = 0, pipeline invalid, accumulator = 0, collisions = 0, collision_valid = 0, rd_data = 0.
REQ-031 After rst, the FSM SHALL enter INIT, clearing both banks (1280 cycles) with wr_ready = 0 and erase_busy = 1, then go to IDLE.
REQ-032 rst mid-erase or mid-write SHALL abort the operation and restart INIT.

Structure
REQ-033 The shared package SHALL hold LB_WIDTH = 640, the entry field positions (COLOR, Z, COLL_MASK), and the erase state encoding.
REQ-034 SHALL instantiate one sub-module, lb_bank_ram (640x16, one registered read port, one write port, read-before-write), twice.

Verification
REQ-035 Bench SHALL check post-reset INIT: wr_ready = 0 for 1280 cycles; afterwards every rd_idx reads 0.
REQ-036 Bench SHALL check first-wins: write idx 5 color 0x22, then idx 5 color 0x33; after swap, rd_idx 5 -> 0x0022 with z preserved.
REQ-037 Bench SHALL check collision: write idx 10 mask 4'b0011, then idx 10 mask 4'b0110 (both opaque); the next line_render_start gives collisions = 4'b0010 and one collision_valid pulse.
REQ-038 Bench SHALL check transparent and out-of-range writes: color 0 at idx 7 -> entry stays 0; idx 700 -> no RAM change; wr_ready stays 1.
REQ-039 Bench SHALL check erase: fill the display bank, pulse erase_start; erase_busy high 640 cycles; all entries then 0; a read during erase returns old data.
REQ-040 Bench SHALL check a swap mid-erase at pointer 300: wr_ready = 0 until pointer reaches 639, held writes then commit, and the new display bank is untouched.
